// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding, port IDs and phase-length defaults for the SRAM arbiter
package sram_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   localparam int DEF_SETUP_CYC  = 1;
   localparam int DEF_STROBE_CYC = 2;
   localparam int DEF_HOLD_CYC   = 1;

   localparam int TIMER_W = 4;

   // The timer counts down to zero, so a window of N cycles loads N-1.
   function automatic logic [TIMER_W-1:0] phase_load(input int cyc);
      return TIMER_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter whose zero flag marks the last cycle of a phase
module sram_phase_timer
   import sram_arb_pkg::*;
(
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - two-port arbiter and CE/OE/WE sequencer for the 16x4 async SRAM
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed port-0 priority.
module sram_access_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 4,
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC
)(
   input  logic              MasterClock,
   input  logic              ResetN,
   input  logic              Req0,
   input  logic              Req1,
   input  logic              Wr0,
   input  logic              Wr1,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [DATA_W-1:0] WData0,
   input  logic [DATA_W-1:0] WData1,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              Done0,
   output logic              Done1,
   output logic [DATA_W-1:0] RData0,
   output logic [DATA_W-1:0] RData1,
   output logic              Busy,
   output logic [ADDR_W-1:0] AD,
   inout  wire  [DATA_W-1:0] DT,
   output logic              CE,
   output logic              OE,
   output logic              WE
);

   logic [1:0]        state_q, state_d;
   logic              port_q, port_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              ce_q, ce_d, oe_q, oe_d, we_q, we_d, dt_en_q, dt_en_d;

   logic               grant, winner;
   logic               tmr_load, tmr_zero;
   logic [TIMER_W-1:0] tmr_val;

   // The Done cycle is deliberately excluded from arbitration so CE stays high for a turnaround cycle.
   assign grant = (state_q == ST_IDLE) && (done_q == 2'b00) && (Req0 || Req1);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   assign winner = (Req0 && Req1) ? ~last_q : Req1;
   assign last_d = grant ? winner : last_q;

   always_ff @(posedge MasterClock) begin
      if (!ResetN) begin
         last_q <= PORT1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign winner = Req0 ? PORT0 : PORT1;
`endif

   sram_phase_timer u_timer (
      .clk_i      (MasterClock),
      .resetn_i   (ResetN),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      port_d   = port_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      gnt_d    = gnt_q;
      done_d   = 2'b00;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      tmr_load = 1'b0;
      tmr_val  = phase_load(SETUP_CYC);
      case (state_q)
         ST_IDLE: begin
            if (done_q != 2'b00) begin
               gnt_d = 2'b00;
            end else if (grant) begin
               port_d   = winner;
               wr_d     = winner ? Wr1 : Wr0;
               addr_d   = winner ? Addr1 : Addr0;
               wdata_d  = winner ? WData1 : WData0;
               gnt_d    = winner ? 2'b10 : 2'b01;
               state_d  = ST_SETUP;
               tmr_load = 1'b1;
               tmr_val  = phase_load(SETUP_CYC);
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_STROBE;
               tmr_load = 1'b1;
               tmr_val  = phase_load(STROBE_CYC);
            end
         end
         ST_STROBE: begin
            if (tmr_zero) begin
               state_d  = ST_HOLD;
               tmr_load = 1'b1;
               tmr_val  = phase_load(HOLD_CYC);
               if (!wr_q) begin
                  if (port_q == PORT1) begin
                     rdata1_d = DT;
                  end else begin
                     rdata0_d = DT;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               state_d = ST_IDLE;
               done_d  = (port_q == PORT1) ? 2'b10 : 2'b01;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so the pins come straight from flops.
   always_comb begin
      ce_d    = (state_d == ST_IDLE);
      oe_d    = !(!wr_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE)));
      we_d    = !(wr_d && (state_d == ST_STROBE));
      dt_en_d = wr_d && (state_d != ST_IDLE);
   end

   always_ff @(posedge MasterClock) begin
      if (!ResetN) begin
         state_q  <= ST_IDLE;
         port_q   <= PORT0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ce_q     <= 1'b1;
         oe_q     <= 1'b1;
         we_q     <= 1'b1;
         dt_en_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         port_q   <= port_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ce_q     <= ce_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
         dt_en_q  <= dt_en_d;
      end
   end

   assign DT     = dt_en_q ? wdata_q : {DATA_W{1'bz}};
   assign AD     = addr_q;
   assign CE     = ce_q;
   assign OE     = oe_q;
   assign WE     = we_q;
   assign Gnt0   = gnt_q[0];
   assign Gnt1   = gnt_q[1];
   assign Done0  = done_q[0];
   assign Done1  = done_q[1];
   assign RData0 = rdata0_q;
   assign RData1 = rdata1_q;
   assign Busy   = (state_q != ST_IDLE);

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Sequencing controller and two-port arbiter for the embedded 16x4 asynchronous SRAM on the RAM demo board. Two requesters (e.g. the switch/key user port and a display-refresh scanner) issue read/write transactions; the block arbitrates between them, latches the winning command, and generates correctly phased active-low CE/OE/WE strobes with setup, strobe and hold windows. It owns the SRAM address bus and the bidirectional data bus, and returns read data and a completion pulse to the served port.

## Interface
- ADDR_W, 4, SRAM address width
- DATA_W, 4, SRAM data width
- SETUP_CYC, 1, cycles of address/CE (and write data) before strobe; legal range 1..15
- STROBE_CYC, 2, cycles WE or OE held low; legal range 1..15
- HOLD_CYC, 1, cycles of address/CE (and write data) after strobe; legal range 1..15

- MasterClock  in  1  board oscillator clock; only clock in the block
- ResetN  in  1  synchronous, active-low reset
- Req0, Req1  in  1  level request, held until Done of that port
- Wr0, Wr1  in  1  1 = write, 0 = read; sampled with Req at grant
- Addr0, Addr1  in  ADDR_W  transaction address
- WData0, WData1  in  DATA_W  write data
- Gnt0, Gnt1  out  1  high from first SETUP cycle through Done cycle of that port's transaction
- Done0, Done1  out  1  one-cycle completion pulse
- RData0, RData1  out  DATA_W  last read data for that port; held until next read on that port completes
- Busy  out  1  high in every non-IDLE state
- AD  out  ADDR_W  SRAM address
- DT  inout  DATA_W  SRAM data; driven only during write transactions, else high-Z
- CE, OE, WE  out  1  SRAM controls, active-low, registered

## Operation
- States: IDLE, SETUP, STROBE, HOLD. A shared down-counter sets phase lengths.
- IDLE: CE=OE=WE=1, DT=Z. Arbitration occurs on each IDLE cycle except the Done cycle (first IDLE cycle after HOLD). On a winning Req, latch Wr/Addr/WData and port ID, assert Gnt, go to SETUP.
- SETUP (SETUP_CYC): CE=0, AD=latched address; write: DT driven; read: OE=0 from first SETUP cycle.
- STROBE (STROBE_CYC): write: WE=0, DT driven; read: OE=0, DT sampled into the port's RData register at the clock edge ending the last STROBE cycle.
- HOLD (HOLD_CYC): WE=1, OE=1, CE=0, AD and (write) DT still driven.
- After HOLD: go to IDLE; Done of served port high for exactly that one cycle; Gnt drops on the following edge.
- Req dropped during a transaction: transaction completes normally; Done still pulses.
- Requesters deassert Req on the edge after seeing Done; a Req still high one cycle after Done is treated as a new request.
- Never more than one Gnt high; WE and OE are never both low.

## Timing
- Reset values: CE=OE=WE=1, DT=Z, AD=0, Gnt*=0, Done*=0, RData*=0, Busy=0, state IDLE, priority pointer favours port 0.
- Latency with defaults: Req high before edge 0 → SETUP cycle 1, STROBE cycles 2–3, HOLD cycle 4, Done in cycle 5. General: Done in cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
- Back-to-back: minimum 2 IDLE cycles between transactions (Done cycle plus arbitration cycle), which guarantees bus turnaround with CE=1 between a write and a following read.
- ResetN low mid-transaction: at the next edge all strobes go high, DT goes Z, Gnt clears, no Done is issued, and RData keeps its reset value of 0.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous Req0/Req1, the port not served most recently wins; the pointer updates on each grant.
- Not defined: fixed priority, port 0 always wins ties; port 1 can starve.

## Structure
- Shared package sram_arb_pkg: state encoding constants (IDLE, SETUP, STROBE, HOLD), port-ID constants, and default phase-length constants.
- One sub-module: sram_phase_timer, a loadable down-counter with a zero flag used for all three phase windows.

## Test plan
- Write port 0: Addr0=4'h3, WData0=4'hA → CE low cycles 1–4, WE low cycles 2–3, DT=4'hA cycles 1–4, Done0 in cycle 5.
- Read port 1 after that write: Addr1=4'h3 → OE low cycles 1–3, RData1=4'hA at Done1, DT never driven by the block.
- Simultaneous Req0/Req1 held high: with SRAM_ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1. Without it, port 0 is granted every time.
- ResetN low during STROBE of a write → next edge: WE=CE=1, DT=Z, Gnt0=0, no Done0.
- Req0 pulsed for one cycle → full transaction completes and Done0 pulses once; no second grant.
- SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2 read → Done in cycle 8. Assert that WE and OE are never both low and that Gnt0/Gnt1 are never high together, across all tests.
